// File: rtl/zint_pos.sv
`default_nettype none
// ============================================================================
// Module   : zint_pos
// Purpose  : Frame interrupt position generator. A free-running raster
//            counter (hcnt, vcnt) is compared against an active INT position.
//            A one-cycle int_start pulse is issued the cycle after a match.
//            Position/enable writes are staged in pending registers and
//            promoted to active only at a frame boundary.
// Revision : 1.0 - initial release
// ============================================================================
module zint_pos #(
    parameter int H_TOTAL = 1792,   // fclk cycles per line, must fit 11 bits
    parameter int V_TOTAL = 320,    // lines per frame, must fit 9 bits
    parameter int H_DEF   = 0,      // reset horizontal INT position
    parameter int V_DEF   = 0       // reset vertical INT position
) (
    input  logic        fclk,
    input  logic        rst,
    input  logic        frame_sync,
    input  logic        cfg_we,
    input  logic [10:0] cfg_h,
    input  logic [8:0]  cfg_v,
    input  logic        cfg_en,
    output logic        int_start,
    output logic [10:0] hcnt,
    output logic [8:0]  vcnt,
    output logic        cfg_bad
);

    localparam logic [10:0] c_H_LAST  = 11'(H_TOTAL - 1);
    localparam logic [8:0]  c_V_LAST  = 9'(V_TOTAL - 1);
    // One extra bit so that H_TOTAL = 2048 / V_TOTAL = 512 stay representable.
    localparam logic [11:0] c_H_LIM   = 12'(H_TOTAL);
    localparam logic [9:0]  c_V_LIM   = 10'(V_TOTAL);
    localparam logic [10:0] c_H_DEF   = 11'(H_DEF);
    localparam logic [8:0]  c_V_DEF   = 9'(V_DEF);
    localparam logic        c_BAD_DEF = ({1'b0, c_H_DEF} >= c_H_LIM) ||
                                        ({1'b0, c_V_DEF} >= c_V_LIM);

    logic [10:0] hcnt_q, hcnt_d;
    logic [8:0]  vcnt_q, vcnt_d;
    logic [10:0] pend_h_q, pend_h_d, act_h_q, act_h_d;
    logic [8:0]  pend_v_q, pend_v_d, act_v_q, act_v_d;
    logic        pend_en_q, pend_en_d, act_en_q, act_en_d;
    logic        int_start_q, int_start_d;
    logic        cfg_bad_q, cfg_bad_d;
    // Low only until the first edge after reset: the (0,0) shown while held
    // in reset was never actually reached, so it must not fire an INT.
    logic        run_q, run_d;
    logic        frame_bnd;
    logic        match;

    // Raster counter next state; frame_sync overrides the natural advance.
    always_comb begin
        hcnt_d = hcnt_q + 11'd1;
        vcnt_d = vcnt_q;
        if (frame_sync) begin
            hcnt_d = 11'd0;
            vcnt_d = 9'd0;
        end else if (hcnt_q == c_H_LAST) begin
            hcnt_d = 11'd0;
            vcnt_d = (vcnt_q == c_V_LAST) ? 9'd0 : vcnt_q + 9'd1;
        end
    end

    // Frame boundary: the edge that moves the counter to (0,0). A sync that
    // coincides with a natural wrap is the same single boundary.
    always_comb begin
        frame_bnd = frame_sync || ((hcnt_q == c_H_LAST) && (vcnt_q == c_V_LAST));
    end

    // Config staging: writes land in pending; pending (including a write in
    // this very cycle) becomes active only at a frame boundary.
    always_comb begin
        pend_h_d  = cfg_we ? cfg_h  : pend_h_q;
        pend_v_d  = cfg_we ? cfg_v  : pend_v_q;
        pend_en_d = cfg_we ? cfg_en : pend_en_q;
        act_h_d   = frame_bnd ? pend_h_d  : act_h_q;
        act_v_d   = frame_bnd ? pend_v_d  : act_v_q;
        act_en_d  = frame_bnd ? pend_en_d : act_en_q;
        // Range flag tracks the value being loaded so it lines up with act_*.
        cfg_bad_d = ({1'b0, act_h_d} >= c_H_LIM) || ({1'b0, act_v_d} >= c_V_LIM);
    end

    // Position match, registered into the one-cycle INT start pulse.
    always_comb begin
        match       = run_q && act_en_q && !cfg_bad_q &&
                      (hcnt_q == act_h_q) && (vcnt_q == act_v_q);
        int_start_d = match;
        run_d       = 1'b1;
    end

    // State registers; reset forces every output low/default immediately.
    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            hcnt_q      <= 11'd0;
            vcnt_q      <= 9'd0;
            pend_h_q    <= c_H_DEF;
            pend_v_q    <= c_V_DEF;
            pend_en_q   <= 1'b1;
            act_h_q     <= c_H_DEF;
            act_v_q     <= c_V_DEF;
            act_en_q    <= 1'b1;
            int_start_q <= 1'b0;
            cfg_bad_q   <= c_BAD_DEF;
            run_q       <= 1'b0;
        end else begin
            hcnt_q      <= hcnt_d;
            vcnt_q      <= vcnt_d;
            pend_h_q    <= pend_h_d;
            pend_v_q    <= pend_v_d;
            pend_en_q   <= pend_en_d;
            act_h_q     <= act_h_d;
            act_v_q     <= act_v_d;
            act_en_q    <= act_en_d;
            int_start_q <= int_start_d;
            cfg_bad_q   <= cfg_bad_d;
            run_q       <= run_d;
        end
    end

    assign int_start = int_start_q;
    assign hcnt      = hcnt_q;
    assign vcnt      = vcnt_q;
    assign cfg_bad   = cfg_bad_q;

endmodule
`default_nettype wire
